// File: rtl/lrot4_seq.sv
// lrot4_seq: 4-bit rotate-left controller built from two passes through Lshift4_gen.
// Define LROT4_SHIFT_MODE_EN to enable i_in_mode=1 as a single-pass logical shift left.

module Lshift4_gen (
    input  logic [3:0] i_a,
    input  logic [1:0] i_amt,
    output logic [3:0] o_y
);
    assign o_y = i_a << i_amt;
endmodule

module lrot4_seq (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [3:0] i_in_data,
    input  logic [1:0] i_in_amt,
    input  logic       i_in_mode,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [3:0] o_out_data
);
    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

    state_e     r_state;
    logic [3:0] r_a;
    logic [1:0] r_k;
    logic [3:0] r_p1;
    logic [3:0] r_sh_data;
    logic [1:0] r_sh_amt;
    logic [3:0] r_out_data;
    logic       r_out_valid;
    logic [3:0] w_sh_out;
    logic [1:0] w_amt2;
    logic       w_shift_mode;

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

`ifdef LROT4_SHIFT_MODE_EN
    logic r_mode;
    assign w_shift_mode = r_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = i_in_mode;
    assign w_shift_mode  = 1'b0;
`endif

    // (4 - k) & 3 as a wrapping 2-bit subtract; k = 0 yields 0.
    assign w_amt2 = 2'd0 - r_k;

    Lshift4_gen u_shift (
        .i_a   (r_sh_data),
        .i_amt (r_sh_amt),
        .o_y   (w_sh_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_a         <= 4'd0;
            r_k         <= 2'd0;
            r_p1        <= 4'd0;
            r_sh_data   <= 4'd0;
            r_sh_amt    <= 2'd0;
            r_out_data  <= 4'd0;
            r_out_valid <= 1'b0;
`ifdef LROT4_SHIFT_MODE_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a       <= i_in_data;
                        r_k       <= i_in_amt;
                        r_sh_data <= i_in_data;
                        r_sh_amt  <= i_in_amt;
`ifdef LROT4_SHIFT_MODE_EN
                        r_mode    <= i_in_mode;
`endif
                        r_state   <= StPass1;
                    end
                end
                StPass1: begin
                    if (w_shift_mode) begin
                        r_out_data  <= w_sh_out;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_p1      <= w_sh_out;
                        r_sh_data <= rev4(r_a);
                        r_sh_amt  <= w_amt2;
                        r_state   <= StPass2;
                    end
                end
                StPass2: begin
                    // rev(rev(A) << (4-k)) is A >> (4-k), the wrapped-around bits.
                    r_out_data  <= r_p1 | rev4(w_sh_out);
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle) && !i_rst;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
endmodule

// File: tb/tb_lrot4_seq.sv
// Directed and sweep bench for lrot4_seq with a scoreboard queue of expected results.
module tb_lrot4_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    lrot4_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_amt    (in_amt),
        .i_in_mode   (in_mode),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rot_model(input logic [3:0] a, input logic [1:0] k);
        logic [7:0] t;
        t = {a, a} << k;
        return t[7:4];
    endfunction

    function automatic logic [3:0] shl_model(input logic [3:0] a, input logic [1:0] k);
        logic [7:0] t;
        t = {4'b0000, a} << k;
        return t[3:0];
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'(1));
    endtask

    // Result is on the outputs: compare with the scoreboard head, then hand it off.
    task automatic collect(input string tag);
        logic [3:0] e;
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_qsize"}, 32'(exp_q.size()), 32'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(out_data), 32'(e));
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_drop"}, 32'(out_valid), 32'(0));
        check({tag, "_rdy_after"}, 32'(in_ready), 32'(1));
    endtask

    task automatic issue(input logic [3:0] a, input logic [1:0] k, input logic m,
                         output logic shift);
`ifdef LROT4_SHIFT_MODE_EN
        shift = m;
`else
        shift = 1'b0;
`endif
        in_valid = 1'b1;
        in_data  = a;
        in_amt   = k;
        in_mode  = m;
        exp_q.push_back(shift ? shl_model(a, k) : rot_model(a, k));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_req(input logic [3:0] a, input logic [1:0] k, input logic m,
                           input string tag);
        logic shift;
        int   lat;
        wait_ready(tag);
        issue(a, k, m, shift);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(shift ? 1 : 2));
        collect(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   idx[64];
        int   j;
        int   tmp;
        int   lat;
        logic shift;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_amt    = 2'd0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'(1));
        tick();

        out_ready = 1'b1;
        run_req(4'b1001, 2'd1, 1'b0, "rot_1001_k1");
        run_req(4'b1000, 2'd3, 1'b0, "rot_1000_k3");
        run_req(4'b1010, 2'd0, 1'b0, "rot_1010_k0");
        run_req(4'b1011, 2'd2, 1'b1, "mode1_1011_k2");

        // Backpressure: result held for 5 cycles, stray request ignored.
        out_ready = 1'b0;
        wait_ready("bp");
        issue(4'b0110, 2'd1, 1'b0, shift);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'(2));
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 32'(out_valid), 32'(1));
            check("bp_hold_data", 32'(out_data), 32'(rot_model(4'b0110, 2'd1)));
            check("bp_hold_ready", 32'(in_ready), 32'(0));
            in_valid = (c == 2);
            in_data  = 4'b1111;
            in_amt   = 2'd2;
            tick();
        end
        in_valid = 1'b0;
        collect("bp_release");
        run_req(4'b0101, 2'd3, 1'b0, "bp_next");

        // Reset while in PASS2 abandons the request.
        wait_ready("rstmid");
        issue(4'b0111, 2'd1, 1'b0, shift);
        tick();
        check("rstmid_pre_valid", 32'(out_valid), 32'(0));
        rst = 1'b1;
        tick();
        void'(exp_q.pop_back());
        check("rstmid_valid", 32'(out_valid), 32'(0));
        check("rstmid_data", 32'(out_data), 32'(0));
        check("rstmid_ready_in_rst", 32'(in_ready), 32'(0));
        rst = 1'b0;
        #1;
        check("rstmid_ready", 32'(in_ready), 32'(1));
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("rstmid_no_stale", 32'(seen), 32'(0));
        run_req(4'b1100, 2'd1, 1'b0, "rstmid_next");

        // Sweep every (A, k) rotate pair in shuffled order.
        for (int i = 0; i < 64; i++) idx[i] = i;
        for (int i = 63; i > 0; i--) begin
            j      = int'($urandom_range(i, 0));
            tmp    = idx[i];
            idx[i] = idx[j];
            idx[j] = tmp;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            run_req(4'(idx[i] >> 2), 2'(idx[i] & 3), 1'b0, "sweep");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
